// File: rtl/jk_counter_ctrl.sv
// Run/pause/stop/reload sequencer for a WIDTH-bit JK flip-flop counter bank.
// Optional feature: define JK_CTRL_DONE_CNT_EN to add the saturating done_cnt output.
module jk_counter_ctrl #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             up,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             busy,
    output logic             done
`ifdef JK_CTRL_DONE_CNT_EN
    ,
    output logic [7:0]       done_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             at_term;
    logic             step;
    logic             load;
    logic             chain;
    logic [WIDTH-1:0] step_jk;
    logic [WIDTH-1:0] drive_j;
    logic [WIDTH-1:0] drive_k;

    // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
    always_comb begin
        step_jk    = '0;
        step_jk[0] = 1'b1;
        chain      = 1'b1;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            chain      = chain & (up ? count[i-1] : ~count[i-1]);
            step_jk[i] = chain;
        end
    end

    always_comb begin
        state_next = state;
        step       = 1'b0;
        load       = 1'b0;
        at_term    = (state == RUN) && (count == term_val);
        if (stop) begin
            state_next = IDLE;
        end else if (start && (state == IDLE || state == DONE)) begin
            state_next = RUN;
            load       = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (pause) begin
                        state_next = PAUSE;
                    end else if (at_term) begin
                        if (auto_reload) load = 1'b1;
                        else             state_next = DONE;
                    end else begin
                        step = 1'b1;
                    end
                end
                PAUSE: begin
                    if (!pause) state_next = RUN;
                end
                default: ;
            endcase
        end
    end

    // Loads use J=d, K=~d; steps use J=K=toggle mask; otherwise J=K=0 holds.
    always_comb begin
        drive_j = '0;
        drive_k = '0;
        if (load) begin
            drive_j = load_val;
            drive_k = ~load_val;
        end else if (step) begin
            drive_j = step_jk;
            drive_k = step_jk;
        end
    end

    assign jk_j = step ? step_jk : '0;
    assign jk_k = step ? step_jk : '0;
    assign busy = (state == RUN) || (state == PAUSE);
    assign done = at_term;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= (drive_j & ~count) | (~drive_k & count);
        end
    end

`ifdef JK_CTRL_DONE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_cnt <= '0;
        end else if (stop) begin
            done_cnt <= '0;
        end else if (done && done_cnt != 8'hFF) begin
            done_cnt <= done_cnt + 8'd1;
        end
    end
`endif

endmodule
